// File: rtl/sort_frame_packer_pkg.sv
// Shared definitions for the frame packer and the sorter that consumes its frames:
// word width, pad sentinels and the packer state type.
package sort_frame_packer_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] SENT_MIN = 16'h8000;
    localparam logic [WORD_W-1:0] SENT_MAX = 16'h7FFF;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    // A sorter keeping the largest values must never pick a pad, so pad with the minimum.
    function automatic logic [WORD_W-1:0] pad_word(input int sortdir);
        return (sortdir != 0) ? SENT_MIN : SENT_MAX;
    endfunction

endpackage

// File: rtl/sort_frame_packer.sv
// Collects a stream of Q9.6 samples into a 2^N-word frame and presents it for one cycle,
// padding unused words with a sentinel chosen so the downstream sorter ignores them.
module sort_frame_packer
    import sort_frame_packer_pkg::*;
#(
    parameter int N       = 10,
    parameter int SORTDIR = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [WORD_W-1:0]           s_data,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [(1<<N)*WORD_W-1:0]    frame_data,
    output logic                        frame_valid,
    output logic [N:0]                  frame_len,
    output logic                        frame_padded,
    output logic                        state_dbg
);

    localparam int                DEPTH = 1 << N;
    localparam logic [N:0]        FULL  = (N+1)'(DEPTH);
    localparam logic [WORD_W-1:0] PAD   = pad_word(SORTDIR);

    // Handshake: a sample transfers on a rising edge where s_valid && s_ready;
    // upstream holds s_data/s_last stable until then.
    state_t            state;
    state_t            state_nxt;
    logic [N-1:0]      wr_idx;
    logic [N:0]        len_q;
    logic              run_q;
    logic              accept;
    logic              close;
    logic [WORD_W-1:0] mem [DEPTH];

    assign accept = s_valid && s_ready;
    assign close  = accept && (s_last || (wr_idx == {N{1'b1}}));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (close) state_nxt = EMIT;
            EMIT:    state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // run_q holds s_ready low until the first edge after reset release.
    always_comb begin
        s_ready      = run_q && (state == FILL);
        frame_valid  = (state == EMIT);
        frame_padded = (state == EMIT) && (len_q != FULL);
        state_dbg    = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            wr_idx <= '0;
            len_q  <= '0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                wr_idx <= wr_idx + 1'b1;
                if (close) len_q <= {1'b0, wr_idx} + (N+1)'(1);
            end
            if (state == EMIT) wr_idx <= '0;
        end
    end

    // Storage keeps stale words from earlier frames; the output mux hides them.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_idx] <= s_data;
    end

    assign frame_len = len_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_pad_mux
        assign frame_data[WORD_W*i +: WORD_W] = (len_q > (N+1)'(i)) ? mem[i] : PAD;
    end

endmodule

// File: tb/tb_sort_frame_packer.sv
// Bench for sort_frame_packer: two N=3 packers (both sort directions) on one stream,
// plus an N=10 packer for the full-length frame.
module tb_sort_frame_packer;
    import sort_frame_packer_pkg::*;

    localparam int D3  = 8;
    localparam int D10 = 1024;
    localparam int LIM = 16;

    // ---------------- clock / reset ----------------
    logic clk_tb = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk_tb = ~clk_tb;
    always @(posedge clk_tb) cyc++;

    // ---------------- DUT signals ----------------
    logic              s_valid3, s_last3;
    logic [15:0]       s_data3;
    logic              s_ready_hi, s_ready_lo;
    logic [D3*16-1:0]  frame_data_hi, frame_data_lo;
    logic              frame_valid_hi, frame_valid_lo;
    logic [3:0]        frame_len_hi, frame_len_lo;
    logic              frame_padded_hi, frame_padded_lo;
    logic              state_dbg_hi, state_dbg_lo;

    logic              s_valid10, s_last10;
    logic [15:0]       s_data10;
    logic              s_ready10;
    logic [D10*16-1:0] frame_data10;
    logic              frame_valid10;
    logic [10:0]       frame_len10;
    logic              frame_padded10;
    logic              state_dbg10;

    sort_frame_packer #(.N(3), .SORTDIR(1)) dut_hi (
        .clk(clk_tb), .rst(rst_n), .s_valid(s_valid3), .s_data(s_data3), .s_last(s_last3),
        .s_ready(s_ready_hi), .frame_data(frame_data_hi), .frame_valid(frame_valid_hi),
        .frame_len(frame_len_hi), .frame_padded(frame_padded_hi), .state_dbg(state_dbg_hi)
    );

    sort_frame_packer #(.N(3), .SORTDIR(0)) dut_lo (
        .clk(clk_tb), .rst(rst_n), .s_valid(s_valid3), .s_data(s_data3), .s_last(s_last3),
        .s_ready(s_ready_lo), .frame_data(frame_data_lo), .frame_valid(frame_valid_lo),
        .frame_len(frame_len_lo), .frame_padded(frame_padded_lo), .state_dbg(state_dbg_lo)
    );

    sort_frame_packer #(.N(10), .SORTDIR(1)) dut_w (
        .clk(clk_tb), .rst(rst_n), .s_valid(s_valid10), .s_data(s_data10), .s_last(s_last10),
        .s_ready(s_ready10), .frame_data(frame_data10), .frame_valid(frame_valid10),
        .frame_len(frame_len10), .frame_padded(frame_padded10), .state_dbg(state_dbg10)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          exp_len_q[$];
    logic [15:0] cur_q[$];
    int          pulse_cyc_q[$];
    int          closes3 = 0;
    int          seen3   = 0;
    int          pulses10 = 0;
    logic        mon_on = 1'b0;

    // Driven at a falling edge; returns at the falling edge after the accepting edge.
    task automatic push3(input logic [15:0] d, input logic l);
        int guard;
        guard = 0;
        s_valid3 = 1'b1;
        s_data3  = d;
        s_last3  = l;
        while (!s_ready_hi && guard < LIM) begin
            @(negedge clk_tb);
            guard++;
        end
        if (guard >= LIM) begin
            check("push3_ready_timeout", 32'(guard), 32'(0));
        end else begin
            @(posedge clk_tb);
            cur_q.push_back(d);
            if (l || cur_q.size() == D3) begin
                exp_len_q.push_back(cur_q.size());
                foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
                cur_q.delete();
                closes3++;
            end
            @(negedge clk_tb);
        end
        s_valid3 = 1'b0;
        s_last3  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_tb);
    endtask

    // Every cycle: a pulse must appear exactly when the model closed a frame on the last edge.
    always @(negedge clk_tb) begin
        if (mon_on) begin
            logic        pend;
            int          elen;
            logic [15:0] ew;
            pend = (closes3 != seen3);
            check("fv_hi", 32'(frame_valid_hi), 32'(pend));
            check("fv_lo", 32'(frame_valid_lo), 32'(pend));
            check("ready_hi", 32'(s_ready_hi), 32'(!pend));
            check("ready_lo", 32'(s_ready_lo), 32'(!pend));
            check("state_hi", 32'(state_dbg_hi), 32'(pend));
            if (frame_valid_hi) pulse_cyc_q.push_back(cyc);
            if (pend) begin
                seen3++;
                elen = exp_len_q.pop_front();
                check("len_hi", 32'(frame_len_hi), 32'(elen));
                check("len_lo", 32'(frame_len_lo), 32'(elen));
                check("padded_hi", 32'(frame_padded_hi), 32'(elen < D3));
                check("padded_lo", 32'(frame_padded_lo), 32'(elen < D3));
                for (int j = 0; j < D3; j++) begin
                    ew = (j < elen) ? exp_q.pop_front() : 16'h0;
                    check($sformatf("word_hi[%0d]", j), 32'(frame_data_hi[16*j +: 16]),
                          32'((j < elen) ? ew : SENT_MIN));
                    check($sformatf("word_lo[%0d]", j), 32'(frame_data_lo[16*j +: 16]),
                          32'((j < elen) ? ew : SENT_MAX));
                end
            end
        end
    end

    always @(negedge clk_tb) begin
        if (frame_valid10) pulses10++;
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        int nframes;
        rst_n     = 1'b0;
        s_valid3  = 1'b0; s_data3  = '0; s_last3  = 1'b0;
        s_valid10 = 1'b0; s_data10 = '0; s_last10 = 1'b0;

        // reset values
        idle(2);
        check("rst_ready", 32'(s_ready_hi), 32'(0));
        check("rst_fv", 32'(frame_valid_hi), 32'(0));
        check("rst_len", 32'(frame_len_hi), 32'(0));
        check("rst_padded", 32'(frame_padded_hi), 32'(0));
        check("rst_state", 32'(state_dbg_hi), 32'(FILL));
        check("rst_ready10", 32'(s_ready10), 32'(0));
        rst_n = 1'b1;
        @(negedge clk_tb);
        check("ready_after_rst", 32'(s_ready_hi), 32'(1));
        mon_on = 1'b1;

        // {5,-2,7} with s_last: padded frame, both pad sentinels
        push3(16'd5, 1'b0);
        push3(16'hFFFE, 1'b0);
        push3(16'd7, 1'b1);
        idle(3);
        check("hold_len", 32'(frame_len_hi), 32'(3));
        check("hold_w0", 32'(frame_data_hi[15:0]), 32'(5));
        check("hold_w5", 32'(frame_data_hi[95:80]), 32'(SENT_MIN));

        // s_last on index 0, then s_last on index 7
        push3(16'h1234, 1'b1);
        idle(2);
        for (int i = 0; i < D3; i++) push3(16'(16'h0100 + i), (i == D3 - 1));
        idle(2);

        // 24 back-to-back samples, no s_last: three full frames 9 cycles apart
        pulse_cyc_q.delete();
        for (int i = 0; i < 24; i++) push3(16'(16'h2000 + i), 1'b0);
        idle(2);
        check("cont_pulses", 32'(pulse_cyc_q.size()), 32'(3));
        if (pulse_cyc_q.size() == 3) begin
            check("cont_gap0", 32'(pulse_cyc_q[1] - pulse_cyc_q[0]), 32'(9));
            check("cont_gap1", 32'(pulse_cyc_q[2] - pulse_cyc_q[1]), 32'(9));
        end

        // reset after 4 samples discards them; 8 fresh samples make one frame
        for (int i = 0; i < 4; i++) push3(16'(16'hDEAD + i), 1'b0);
        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("mid_rst_ready", 32'(s_ready_hi), 32'(0));
        check("mid_rst_len", 32'(frame_len_hi), 32'(0));
        cur_q.delete();
        idle(2);
        rst_n = 1'b1;
        @(negedge clk_tb);
        check("mid_rst_ready_up", 32'(s_ready_hi), 32'(1));
        mon_on = 1'b1;
        pulse_cyc_q.delete();
        for (int i = 0; i < D3; i++) push3(16'(16'h3000 + i), 1'b0);
        idle(3);
        check("rst_frame_pulses", 32'(pulse_cyc_q.size()), 32'(1));

        // random gaps and random s_last positions
        for (int i = 0; i < 60; i++) begin
            idle($urandom_range(0, 1));
            push3(16'($urandom_range(0, 65535)), ($urandom_range(0, 4) == 0));
        end
        push3(16'h7777, 1'b1);
        idle(3);

        // N=10 full frame, value(i) = 1023-i, s_last on the final word
        for (int i = 0; i < D10; i++) begin
            s_valid10 = 1'b1;
            s_data10  = 16'(D10 - 1 - i);
            s_last10  = (i == D10 - 1);
            guard = 0;
            while (!s_ready10 && guard < LIM) begin
                @(negedge clk_tb);
                guard++;
            end
            if (guard >= LIM) check("push10_ready_timeout", 32'(guard), 32'(0));
            @(negedge clk_tb);
        end
        s_valid10 = 1'b0;
        s_last10  = 1'b0;
        check("w_fv", 32'(frame_valid10), 32'(1));
        check("w_len", 32'(frame_len10), 32'(D10));
        check("w_padded", 32'(frame_padded10), 32'(0));
        check("w_ready_emit", 32'(s_ready10), 32'(0));
        for (int j = 0; j < D10; j++)
            check($sformatf("w_word[%0d]", j), 32'(frame_data10[16*j +: 16]), 32'(D10 - 1 - j));
        @(negedge clk_tb);
        check("w_fv_drop", 32'(frame_valid10), 32'(0));
        idle(2);

        // wrap-up
        nframes = exp_len_q.size();
        check("leftover_frames", 32'(nframes), 32'(0));
        check("w_pulse_count", 32'(pulses10), 32'(1));
        check("frames_seen", 32'(seen3), 32'(closes3));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sort_frame_packer.md
SORT_FRAME_PACKER -- requirements
Module: sort_frame_packer

Interface
REQ-001 Parameter N, default 10: log2 of frame length in 16-bit words; frame holds 2^N words.
REQ-002 Parameter SORTDIR, default 1: 1 = downstream sorter keeps largest values, 0 = keeps smallest; selects the pad sentinel.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_data  input  16  signed Q9.6 fixed-point sample.
REQ-007 s_last  input  1  marks final sample of a frame; qualified by s_valid and s_ready.
REQ-008 s_ready  output  1  packer can accept a sample this cycle.
REQ-009 frame_data  output  2^N*16  packed frame; word i occupies bits [16i+15:16i]; drives sorter in_data_raw.
REQ-010 frame_valid  output  1  one-cycle pulse; frame_data holds a complete frame; drives sorter input_valid.
REQ-011 frame_len  output  N+1  number of real (non-pad) words in the emitted frame, 1..2^N; valid with frame_valid.
REQ-012 frame_padded  output  1  high with frame_valid when frame_len < 2^N.

Function
REQ-013 Accept a sample when s_valid && s_ready at a rising edge; store it at word index wr_idx, then increment wr_idx.
REQ-014 States are FILL and EMIT; FILL is the post-reset state.
REQ-015 In FILL: s_ready = 1.
REQ-016 FILL -> EMIT when the accepted sample has wr_idx = 2^N-1, or has s_last = 1.
REQ-017 EMIT lasts exactly one cycle.
REQ-018 In EMIT: frame_valid = 1, s_ready = 0, frame_len = number of words accepted in this frame.
REQ-019 EMIT -> FILL unconditionally; wr_idx clears to 0 on that transition.
REQ-020 Latency: last sample accepted at edge k -> frame_valid high for the cycle between edges k and k+1; sustained throughput is one frame per 2^N+1 cycles.
REQ-021 Words with index >= frame_len read as the sentinel on frame_data: 0x8000 (-32768) when SORTDIR=1, 0x7FFF (+32767) when SORTDIR=0.
REQ-022 Padding is applied at the output mux; the storage is not rewritten.
REQ-023 s_last on sample index 2^N-1 is legal: frame_len = 2^N, frame_padded = 0.
REQ-024 s_last on sample index 0 is legal: frame_len = 1 and the remaining 2^N-1 words are sentinel.
REQ-025 If no s_last arrives, the frame closes at 2^N words and the next accepted sample starts a new frame at index 0; this is not an error.
REQ-026 frame_data and frame_len stay stable from the EMIT cycle until the first sample of the next frame is accepted.
REQ-027 frame_data is don't-care before the first EMIT after reset.
REQ-028 s_valid while s_ready = 0 is ignored and its data is not stored; upstream holds the sample.

Reset
REQ-029 While rst = 0: state = FILL, wr_idx = 0, frame_valid = 0, s_ready = 0, frame_len = 0, frame_padded = 0.
REQ-030 The frame storage array is not reset.
REQ-031 s_ready rises in the first cycle after rst deasserts.
REQ-032 Reset during FILL or EMIT discards the partial or pending frame; no frame_valid pulse follows for it.

Structure
REQ-033 A shared package holds WORD_W = 16, the sentinel constants SENT_MIN = 16'h8000 and SENT_MAX = 16'h7FFF, and the FILL/EMIT state type; the sorter bench imports the same package.
REQ-034 The design is a single module with no sub-modules; the pad mux is inline logic indexed by frame_len.

Verification
REQ-035 N=10: stream 1024 samples, value(i) = 1023-i, s_last on i=1023 -> one frame_valid pulse one cycle after the last acceptance; frame_len = 1024, frame_padded = 0, word i = 1023-i.
REQ-036 N=3, SORTDIR=1: 3 samples {5,-2,7} with s_last on the third -> frame_len = 3, frame_padded = 1, words = {5,-2,7,0x8000 x5}. Repeat with SORTDIR=0 -> the same except pads are 0x7FFF.
REQ-037 N=3, continuous s_valid for 24 samples, no s_last -> exactly 3 pulses, 9 cycles apart; s_ready low only in each EMIT cycle; no sample lost or duplicated.
REQ-038 N=3: assert rst after 4 samples, release, send 8 fresh samples -> exactly one frame_valid pulse, containing only the fresh data.
REQ-039 N=3: random s_valid gaps (50% duty) with s_last at random positions -> each frame's contents and frame_len match a reference model.
REQ-040 N=10, integrated with partial_sorter_general (M=9) -> sorter output_valid follows each frame_valid by the sorter latency, and its top 512 outputs match a reference model of the packed frame including pads.
